// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared opcodes, FSM state encoding and field widths for the SPI flash responder
package spi_flash_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam int ADDR_BITS = 24;
  localparam int CMD_BITS = 8;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-flop synchronizers for SCK/CS/MOSI plus edge pulses; ports: clk, rstn, spi_clk/spi_cs/spi_mosi in; sck_rise, sck_fall, cs_hi, cs_fall, mosi out
module spi_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_hi,
  output logic cs_fall,
  output logic mosi
);
  logic [2:0] sck_q, sck_d, cs_q, cs_d;
  logic [1:0] mosi_q, mosi_d;
  always_comb begin
    sck_d = {sck_q[1:0], spi_clk};
    cs_d = {cs_q[1:0], spi_cs};
    mosi_d = {mosi_q[0], spi_mosi};
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_q <= '0;
      cs_q <= '1;
      mosi_q <= '0;
    end else begin
      sck_q <= sck_d;
      cs_q <= cs_d;
      mosi_q <= mosi_d;
    end
  end
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_hi = cs_q[1];
  assign cs_fall = ~cs_q[1] & cs_q[2];
  assign mosi = mosi_q[1];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-0 SPI flash target (READ 0x03; RDID 0x9F when SPI_FLASH_RESPONDER_READ_ID_EN) streaming backing memory; ports: clk, rstn, SPI_CLK/SPI_CS/SPI_MOSI in, SPI_MISO out, mem_addr/mem_rd_en/mem_rdata memory port, busy, cmd_err
module spi_flash_responder #(
  parameter int ADDR_W = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              SPI_CLK,
  input  logic              SPI_CS,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);
  import spi_flash_pkg::*;
`ifdef SPI_FLASH_RESPONDER_READ_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  logic sck_rise, sck_fall, cs_hi, cs_fall, mosi;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] rx_q, rx_d, rx_sh, addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [7:0] tx_q, tx_d, pf_q, pf_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic id_q, id_d, miso_q, miso_d, rd_q, rd_d, rd_tx_q, rd_tx_d;
  logic cap_q, cap_d, cap_tx_q, cap_tx_d, err_q, err_d;
  spi_edge_sync u_sync (
    .clk(clk), .rstn(rstn), .spi_clk(SPI_CLK), .spi_cs(SPI_CS), .spi_mosi(SPI_MOSI),
    .sck_rise(sck_rise), .sck_fall(sck_fall), .cs_hi(cs_hi), .cs_fall(cs_fall), .mosi(mosi)
  );
  // only the low ADDR_W bits of the shifted address survive; the opcode sits in the low byte
  assign rx_sh = ADDR_W'({rx_q, mosi});
  always_comb begin
    state_d = state_q;
    rx_d = rx_q;
    addr_d = addr_q;
    mem_addr_d = mem_addr_q;
    tx_d = tx_q;
    pf_d = pf_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    id_d = id_q;
    miso_d = miso_q;
    rd_d = 1'b0;
    rd_tx_d = 1'b0;
    cap_d = rd_q;
    cap_tx_d = rd_tx_q;
    err_d = 1'b0;
    if (cs_hi) begin
      state_d = IDLE;
      miso_d = 1'b0;
      cnt_d = '0;
      cap_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cs_fall) begin
          state_d = CMD;
          cnt_d = '0;
        end
        CMD: if (sck_rise) begin
          rx_d = rx_sh;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(CMD_BITS - 1)) begin
            cnt_d = '0;
            if (rx_sh[7:0] == CMD_READ) state_d = ADDR;
            else if (ID_EN && rx_sh[7:0] == CMD_RDID) begin
              state_d = DATA;
              id_d = 1'b1;
              tx_d = JEDEC_ID[23:16];
              idx_d = 2'd1;
            end else begin
              state_d = IGNORE;
              err_d = 1'b1;
            end
          end
        end
        ADDR: if (sck_rise) begin
          rx_d = rx_sh;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ADDR_BITS - 1)) begin
            cnt_d = '0;
            state_d = DATA;
            id_d = 1'b0;
            rd_d = 1'b1;
            rd_tx_d = 1'b1;
            mem_addr_d = rx_sh;
            addr_d = rx_sh + ADDR_W'(1);
          end
        end
        DATA: begin
          // returning read data either fills tx_sr (then prefetches the next byte) or the prefetch buffer
          if (cap_q && cap_tx_q) begin
            tx_d = mem_rdata;
            rd_d = 1'b1;
            mem_addr_d = addr_q;
            addr_d = addr_q + ADDR_W'(1);
          end else if (cap_q) pf_d = mem_rdata;
          if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d = {tx_q[6:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              if (id_q) begin
                tx_d = idx_q == 2'd1 ? JEDEC_ID[15:8] : idx_q == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
                idx_d = idx_q == 2'd3 ? idx_q : idx_q + 2'd1;
              end else begin
                tx_d = pf_q;
                rd_d = 1'b1;
                mem_addr_d = addr_q;
                addr_d = addr_q + ADDR_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rx_q <= '0;
      addr_q <= '0;
      mem_addr_q <= '0;
      tx_q <= '0;
      pf_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      id_q <= 1'b0;
      miso_q <= 1'b0;
      rd_q <= 1'b0;
      rd_tx_q <= 1'b0;
      cap_q <= 1'b0;
      cap_tx_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q <= rx_d;
      addr_q <= addr_d;
      mem_addr_q <= mem_addr_d;
      tx_q <= tx_d;
      pf_q <= pf_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      id_q <= id_d;
      miso_q <= miso_d;
      rd_q <= rd_d;
      rd_tx_q <= rd_tx_d;
      cap_q <= cap_d;
      cap_tx_q <= cap_tx_d;
      err_q <= err_d;
    end
  end
  assign SPI_MISO = miso_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd_en = rd_q;
  assign busy = state_q != IDLE;
  assign cmd_err = err_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: scoreboard bench driving mode-0 SPI reads against a registered backing-memory model
module tb_spi_flash_responder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic SPI_CLK = 1'b0;
  logic SPI_CS = 1'b1;
  logic SPI_MOSI = 1'b0;
  logic SPI_MISO, mem_rd_en, busy, cmd_err;
  logic [15:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [65536];
  logic [7:0] exp_q [$];
  logic [15:0] base_addr = 16'h0;
  logic [15:0] ea;
  int n_vec = 0;
  int n_err = 0;
  int rd_seen = 0;
  int rd_total = 0;
  int err_cnt = 0;
  spi_flash_responder dut (
    .clk(clk), .rstn(rstn), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .busy(busy), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic sck_bit(input logic b, output logic r);
    SPI_MOSI = b;
    repeat (8) @(negedge clk);
    r = SPI_MISO;
    SPI_CLK = 1'b1;
    repeat (8) @(negedge clk);
    SPI_CLK = 1'b0;
  endtask
  task automatic xfer(input logic [7:0] t, output logic [7:0] r);
    logic b;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(t[i], b);
      r = {r[6:0], b};
    end
  endtask
  task automatic cs_on();
    @(negedge clk);
    SPI_CS = 1'b0;
    repeat (8) @(negedge clk);
  endtask
  task automatic cs_off();
    @(negedge clk);
    SPI_CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic start_read(input logic [23:0] a);
    logic [7:0] r;
    base_addr = a[15:0];
    rd_seen = 0;
    cs_on();
    xfer(8'h03, r);
    xfer(a[23:16], r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
  endtask
  task automatic recv(input string tag, input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, r);
      if (exp_q.size() == 0) chk({tag, "_noexp"}, 32'(r), 32'hFFFF_FFFF);
      else chk(tag, 32'(r), 32'(exp_q.pop_front()));
    end
  endtask
  initial begin
    logic [7:0] r;
    logic b0, b1, b2;
    int t, e;
    for (int k = 0; k < 65536; k++) mem[k] = 8'(k) ^ 8'hA5;
    fork
      forever begin
        @(negedge clk);
        if (mem_rd_en) begin
          ea = base_addr + 16'(rd_seen);
          chk("mem_addr", 32'(mem_addr), 32'(ea));
          rd_seen++;
          rd_total++;
        end
        if (cmd_err) err_cnt++;
      end
    join_none
    repeat (4) @(negedge clk);
    chk("rst_miso", 32'(SPI_MISO), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    // basic read, 4 bytes
    exp_q.push_back(8'h27); exp_q.push_back(8'h26); exp_q.push_back(8'h21); exp_q.push_back(8'h20);
    start_read(24'h550082);
    chk("busy_data", 32'(busy), 32'd1);
    recv("rd_550082", 4);
    chk("rd_cnt_550082", 32'(rd_seen >= 5), 32'd1);
    cs_off();
    // address wrap
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    start_read(24'h00FFFF);
    recv("rd_wrap", 2);
    chk("rd_cnt_wrap", 32'(rd_seen >= 3), 32'd1);
    cs_off();
    // unsupported opcode
    t = rd_total;
    e = err_cnt;
    cs_on();
    for (int i = 7; i >= 1; i--) sck_bit(i == 3 || i == 1, b0);
    chk("cmd_err_early", 32'(err_cnt - e), 32'd0);
    sck_bit(1'b1, b0);
    chk("cmd_err_pulse", 32'(err_cnt - e), 32'd1);
    xfer(8'hFF, r);
    chk("ign_miso", 32'(r), 32'd0);
    chk("ign_no_rd", 32'(rd_total - t), 32'd0);
    chk("ign_err_once", 32'(err_cnt - e), 32'd1);
    @(negedge clk);
    SPI_CS = 1'b1;
    @(negedge clk);
    chk("ign_busy_1clk", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("ign_busy_3clk", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    // abort after 3 data bits, then a fresh read
    start_read(24'h000040);
    sck_bit(1'b0, b0);
    sck_bit(1'b0, b1);
    sck_bit(1'b0, b2);
    chk("abort_bits", 32'({b0, b1, b2}), 32'd7);
    @(negedge clk);
    SPI_CS = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_miso", 32'(SPI_MISO), 32'd0);
    repeat (5) @(negedge clk);
    exp_q.push_back(8'hB5); exp_q.push_back(8'hB4);
    start_read(24'h000010);
    recv("rd_restart", 2);
    cs_off();
    // async reset mid-data
    start_read(24'h000200);
    sck_bit(1'b0, b0);
    sck_bit(1'b0, b1);
    repeat (5) @(negedge clk);
    chk("pre_rst_miso", 32'(SPI_MISO), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_miso", 32'(SPI_MISO), 32'd0);
    chk("arst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    SPI_CS = 1'b1;
    repeat (8) @(negedge clk);
    exp_q.push_back(8'h27); exp_q.push_back(8'h26);
    start_read(24'h550082);
    recv("rd_after_rst", 2);
    cs_off();
    // read-ID opcode
    t = rd_total;
    e = err_cnt;
    cs_on();
    xfer(8'h9F, r);
`ifdef SPI_FLASH_RESPONDER_READ_ID_EN
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h17); exp_q.push_back(8'h00);
    chk("rdid_no_err", 32'(err_cnt - e), 32'd0);
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    chk("rdid_err", 32'(err_cnt - e), 32'd1);
`endif
    recv("rdid", 4);
    chk("rdid_no_rd", 32'(rd_total - t), 32'd0);
    cs_off();
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
